// File: rtl/patch_window_gen.sv
// rtl/patch_window_gen.sv - streaming 3x3 sliding-window generator with two line buffers
module patch_window_gen #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW    = 16
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic [DW-1:0]   PIX_IN,
  input  logic            PIX_VALID,
  output logic            PIX_READY,
  output logic [9*DW-1:0] PATCH,
  output logic            PATCH_VALID,
  input  logic            PATCH_READY,
  output logic            FRAME_DONE
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [DW-1:0]   lb0_q [IMG_W];
  logic [DW-1:0]   lb1_q [IMG_W];
  logic [DW-1:0]   win_q [3][3];
  logic [DW-1:0]   win_d [3][3];
  logic [9*DW-1:0] patch_q, patch_d, patch_pack;
  logic            patch_valid_q, patch_valid_d;
  logic            frame_done_q, frame_done_d;
  logic            acc, emit, col_wrap, row_last;

  // Output register is free when empty or being drained this cycle.
  assign PIX_READY = !rst && (!patch_valid_q || PATCH_READY);
  assign acc       = PIX_VALID && PIX_READY;
  assign col_wrap  = (col_q == COL_LAST);
  assign row_last  = (row_q == ROW_LAST);
  assign emit      = acc && (row_q >= RW'(2)) && (col_q >= CW'(2));

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_d[r][0] = win_q[r][1];
      win_d[r][1] = win_q[r][2];
    end
    win_d[0][2] = lb0_q[col_q];
    win_d[1][2] = lb1_q[col_q];
    win_d[2][2] = PIX_IN;
  end

  always_comb begin
    patch_pack = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        patch_pack[(8 - (r * 3 + c)) * DW +: DW] = win_d[r][c];
      end
    end
  end

  always_comb begin
    col_d         = col_q;
    row_d         = row_q;
    patch_d       = patch_q;
    patch_valid_d = patch_valid_q;
    frame_done_d  = 1'b0;
    if (acc) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      frame_done_d = col_wrap && row_last;
    end
    if (emit) begin
      patch_d       = patch_pack;
      patch_valid_d = 1'b1;
    end else if (PATCH_READY) begin
      patch_valid_d = 1'b0;
    end
  end

  // Window and line buffers need no reset: stale entries never reach an emitted patch.
  always_ff @(posedge CLK) begin
    if (acc) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= win_d[r][c];
        end
      end
      lb0_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= PIX_IN;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      col_q         <= '0;
      row_q         <= '0;
      patch_q       <= '0;
      patch_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      col_q         <= col_d;
      row_q         <= row_d;
      patch_q       <= patch_d;
      patch_valid_q <= patch_valid_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign PATCH       = patch_q;
  assign PATCH_VALID = patch_valid_q;
  assign FRAME_DONE  = frame_done_q;

endmodule

// File: doc/patch_window_gen.md
Name: patch_window_gen

Overview:
- Streaming 3x3 sliding-window generator; producer side of the 3x3 convolution datapath.
- Accepts a raster-order pixel stream, one 16-bit pixel per handshake.
- Stores the two previous lines in line buffers.
- Emits every fully-valid 3x3 patch (no padding) in the 9x16 PATCH packing the conv core consumes, with a valid/ready handshake toward the core.

Parameters:
- IMG_W, 8, image width in pixels (>= 3)
- IMG_H, 8, image height in lines (>= 3)
- DW, 16, pixel width in bits; PATCH width = 9*DW

Ports:
- CLK  input  1  clock, all logic rising-edge
- rst  input  1  synchronous, active-high reset
- PIX_IN  input  DW  incoming pixel, raster order (row-major, top-left first)
- PIX_VALID  input  1  PIX_IN valid
- PIX_READY  output  1  block can accept a pixel this cycle
- PATCH  output  9*DW  3x3 window; PATCH[9*DW-1 -: DW] = top-left ... PATCH[DW-1:0] = bottom-right
- PATCH_VALID  output  1  PATCH holds an unconsumed window
- PATCH_READY  input  1  downstream accepts PATCH this cycle
- FRAME_DONE  output  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset, synchronous on CLK when rst=1:
  - col=0, row=0, PATCH_VALID=0, PATCH=0, FRAME_DONE=0.
  - Line buffer and window contents are don't-care.
- Accept: acc = PIX_VALID && PIX_READY.
  - PIX_READY = !PATCH_VALID || PATCH_READY (combinational).
  - PIX_READY is 0 during the reset cycle.
- Storage:
  - Two line buffers LB1 (previous line) and LB0 (line before that), each IMG_W x DW, addressed by col.
  - Window is a 3x3 register array W[r][c], r=0 top, c=0 left.
- On acc at position (row, col):
  - Shift each window row left by one.
  - New right column = {LB0[col], LB1[col], PIX_IN}, top to bottom.
  - LB0[col] <= LB1[col]; LB1[col] <= PIX_IN.
- Emission: if acc && row>=2 && col>=2:
  - Next cycle PATCH = the shifted window packed row-major, with W[0][0] in the MSBs and the new pixel in the LSBs.
  - PATCH_VALID = 1.
  - Latency: 1 cycle from accepting the bottom-right pixel.
- Window validity:
  - col<2 or row<2 windows contain stale data and are never emitted.
  - No clearing at line or frame boundaries is needed.
- Output hold:
  - While PATCH_VALID && !PATCH_READY, PATCH is frozen and PIX_READY=0.
  - Accept and handshake may occur in the same cycle: the old patch is consumed and the new one loads. Zero-bubble throughput of 1 pixel/cycle.
- PATCH_VALID clears when PATCH_READY=1 and no new emitting accept occurs in that cycle.
- Counters:
  - col increments on acc and wraps IMG_W-1 -> 0.
  - When col wraps, row increments; row wraps IMG_H-1 -> 0.
- FRAME_DONE = 1 for exactly one cycle following acc at (IMG_H-1, IMG_W-1). It coincides with the final PATCH_VALID rising.
- Frames run back-to-back; the first pixel of the next frame may be accepted in the FRAME_DONE cycle.
- Patches per frame: (IMG_W-2)*(IMG_H-2).
- Arithmetic: pure data movement, no width change; col/row counters are $clog2 of IMG_W/IMG_H.
- PIX_IN is ignored when !acc.
- Reset mid-frame:
  - Drops any pending patch and restarts at (0,0).
  - The next frame produces correct patches with no residue from the aborted frame.

Test Plan:
- Basic emission: IMG_W=IMG_H=4, continuous PIX_VALID, PATCH_READY=1, pixel = row*4+col+1 (1..16).
  - First PATCH_VALID occurs 1 cycle after accepting pixel 11, with PATCH = {1,2,3,5,6,7,9,10,11}.
  - Patches follow for pixels 12, 15, 16; the last is {6,7,8,10,11,12,14,15,16}.
  - Exactly 4 patches; FRAME_DONE pulses once with the last.
- Backpressure: same stream, PATCH_READY=0 for 5 cycles after the first patch.
  - PATCH stays {1,2,3,5,6,7,9,10,11}; PIX_READY=0 throughout; no pixel lost.
  - After release, the remaining 3 patches are correct.
- Input gaps: PIX_VALID toggles 1/0 each cycle.
  - Same 4 patches and values; PIX_IN driven with 0xDEAD while invalid never appears in PATCH.
- Back-to-back frames: two frames of 1..16 then 101..116, no gap.
  - The second frame's first patch is {101,102,103,105,106,107,109,110,111}; 8 patches total; 2 FRAME_DONE pulses.
- Reset mid-frame: assert rst for 1 cycle after pixel 10 is accepted.
  - PATCH_VALID=0 and FRAME_DONE=0 on the next cycle.
  - Re-sent full frame 1..16 yields exactly the 4 basic-emission patches.
- Non-square: IMG_W=5, IMG_H=3, pixels 1..15.
  - 3 patches: {1,2,3,6,7,8,11,12,13}, {2,3,4,7,8,9,12,13,14}, {3,4,5,8,9,10,13,14,15}.
